multicore_cpu_1_cpu_debug_mem: RTL

MULTICORE_CPU_1_CPU_DEBUG_MEM -- requirements
Module: multicore_cpu_1_cpu_debug_mem

---
 rtl/multicore_cpu_1_cpu_debug_mem_if.sv | 24 ++
 rtl/multicore_cpu_1_cpu_debug_mem.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/multicore_cpu_1_cpu_debug_mem_if.sv
// CPU-side slave bus of the debug RAM: Avalon-style request with waitrequest back-pressure.
interface multicore_cpu_1_cpu_debug_mem_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              read;
    logic              write;
    logic [31:0]       writedata;
    logic [3:0]        byteenable;
    logic              debugaccess;
    logic [31:0]       readdata;
    logic              waitrequest;

    modport master (
        output address, chipselect, read, write, writedata, byteenable, debugaccess,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, chipselect, read, write, writedata, byteenable, debugaccess,
        output readdata, waitrequest
    );
endinterface

// File: rtl/multicore_cpu_1_cpu_debug_mem.sv
// Debug RAM shared by the JTAG monitor path (MonAReg/MonDReg) and a CPU slave port.
// JTAG requests sit in a single pending slot and win arbitration over the CPU.
module multicore_cpu_1_cpu_debug_mem #(
    parameter int ADDR_W = 8
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [37:0]                      jdo,
    input  logic                             take_action_ocimem_a,
    input  logic                             take_no_action_ocimem_a,
    input  logic                             take_action_ocimem_b,
    multicore_cpu_1_cpu_debug_mem_if.slave   cpu,
    output logic [31:0]                      MonDReg,
    output logic [ADDR_W-1:0]                MonAReg,
    output logic                             jtag_pending
);

    typedef enum logic [2:0] {IDLE, JRD, JRD2, JWR, CRD, CRD2, CWR, CACK} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mon_a_q, mon_a_d;
    logic [31:0]       mon_d_q, mon_d_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              wait_q, wait_d;
    logic              pend_q, pend_d;
    logic              pend_wr_q, pend_wr_d;
    logic              pend_inc_q, pend_inc_d;
    logic [31:0]       pend_data_q, pend_data_d;
    logic              j_inc_q, j_inc_d;
    logic [31:0]       j_data_q, j_data_d;

    logic              strobe;
    logic              ram_we;
    logic [3:0]        ram_be;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_q;
    logic [31:0]       mem [0:(1<<ADDR_W)-1];

    logic              jdo_unused;
    assign jdo_unused = ^{jdo[37:36], jdo[2:0]};

    assign strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;

    always_comb begin
        state_d     = state_q;
        mon_a_d     = mon_a_q;
        mon_d_d     = mon_d_q;
        rdata_d     = rdata_q;
        pend_d      = pend_q;
        pend_wr_d   = pend_wr_q;
        pend_inc_d  = pend_inc_q;
        pend_data_d = pend_data_q;
        j_inc_d     = j_inc_q;
        j_data_d    = j_data_q;
        ram_we      = 1'b0;
        ram_be      = 4'hF;
        ram_addr    = mon_a_q;
        ram_wdata   = j_data_q;

        unique case (state_q)
            IDLE: begin
                // A strobe arriving this cycle holds off the CPU so JTAG keeps priority.
                if (pend_q) begin
                    state_d  = pend_wr_q ? JWR : JRD;
                    j_inc_d  = pend_inc_q;
                    j_data_d = pend_data_q;
                    pend_d   = 1'b0;
                end else if (!strobe && cpu.chipselect && (cpu.read || cpu.write)) begin
                    state_d = cpu.write ? CWR : CRD;
                end
            end
            JRD: begin
                state_d = JRD2;
            end
            JRD2: begin
                mon_d_d = ram_q;
                if (j_inc_q) mon_a_d = mon_a_q + ADDR_W'(1);
                state_d = IDLE;
            end
            JWR: begin
                ram_we  = 1'b1;
                mon_a_d = mon_a_q + ADDR_W'(1);
                state_d = IDLE;
            end
            CRD: begin
                ram_addr = cpu.address;
                state_d  = CRD2;
            end
            CRD2: begin
                rdata_d = ram_q;
                state_d = CACK;
            end
            CWR: begin
                ram_addr  = cpu.address;
                ram_we    = cpu.debugaccess;
                ram_be    = cpu.byteenable;
                ram_wdata = cpu.writedata;
                state_d   = CACK;
            end
            CACK: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // New strobes overwrite the slot, including one being dispatched this cycle.
        if (take_action_ocimem_b) begin
            pend_d      = 1'b1;
            pend_wr_d   = 1'b1;
            pend_inc_d  = 1'b1;
            pend_data_d = jdo[34:3];
        end else if (take_action_ocimem_a) begin
            mon_a_d = jdo[ADDR_W+24:25];
            if (jdo[35]) begin
                pend_d     = 1'b1;
                pend_wr_d  = 1'b0;
                pend_inc_d = 1'b0;
            end
        end else if (take_no_action_ocimem_a) begin
            pend_d     = 1'b1;
            pend_wr_d  = 1'b0;
            pend_inc_d = 1'b1;
        end

        wait_d = (state_d != CACK);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            mon_a_q     <= '0;
            mon_d_q     <= '0;
            rdata_q     <= '0;
            wait_q      <= 1'b1;
            pend_q      <= 1'b0;
            pend_wr_q   <= 1'b0;
            pend_inc_q  <= 1'b0;
            pend_data_q <= '0;
            j_inc_q     <= 1'b0;
            j_data_q    <= '0;
        end else begin
            state_q     <= state_d;
            mon_a_q     <= mon_a_d;
            mon_d_q     <= mon_d_d;
            rdata_q     <= rdata_d;
            wait_q      <= wait_d;
            pend_q      <= pend_d;
            pend_wr_q   <= pend_wr_d;
            pend_inc_q  <= pend_inc_d;
            pend_data_q <= pend_data_d;
            j_inc_q     <= j_inc_d;
            j_data_q    <= j_data_d;
        end
    end

    // Single-port RAM, one-cycle read latency, contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (ram_be[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
            end
        end
        ram_q <= mem[ram_addr];
    end

    assign MonDReg         = mon_d_q;
    assign MonAReg         = mon_a_q;
    assign jtag_pending    = pend_q;
    assign cpu.readdata    = rdata_q;
    assign cpu.waitrequest = wait_q;

endmodule
